// File: rtl/fifo_rd_stream.sv
// Read-side output stage for the async FIFO: issues r_en against a credit budget and
// presents one-cycle-latency memory data as a valid/ready stream via a 2-entry buffer.
// Optional FIFO_RD_STREAM_CNT_EN adds beat_cnt/stall_cnt outputs.
module fifo_rd_stream #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  r_clk,
  input  logic                  r_rstn,
  input  logic                  r_empty,
  output logic                  r_en,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [1:0]            level
`ifdef FIFO_RD_STREAM_CNT_EN
  ,
  output logic [31:0]           beat_cnt,
  output logic [31:0]           stall_cnt
`endif
);

  logic                  inflight_q, inflight_d;
  logic [1:0]            level_q, level_d;
  logic [DATA_WIDTH-1:0] buf0_q, buf0_d;
  logic [DATA_WIDTH-1:0] buf1_q, buf1_d;
  logic                  pop;
  logic                  push;
  logic [2:0]            credit;

  assign m_valid = (level_q != 2'd0);
  assign m_data  = buf0_q;
  assign level   = level_q;
  assign pop     = m_valid & m_ready;
  assign push    = inflight_q;

  // Credit counts the slot freed by this cycle's pop, so issue can overlap a pop
  // (m_ready -> r_en is combinational on purpose to sustain one word per cycle).
  always_comb begin
    credit     = {1'b0, level_q} + {2'b00, inflight_q} - {2'b00, pop};
    r_en       = r_rstn & ~r_empty & (credit < 3'd2);
    inflight_d = r_en;
  end

  always_comb begin
    buf0_d  = buf0_q;
    buf1_d  = buf1_q;
    level_d = level_q;
    unique case ({push, pop})
      2'b10: begin
        if (level_q == 2'd0) buf0_d = rd_data;
        else                 buf1_d = rd_data;
        level_d = level_q + 2'd1;
      end
      2'b01: begin
        buf0_d  = buf1_q;
        level_d = level_q - 2'd1;
      end
      2'b11: begin
        if (level_q == 2'd1) begin
          buf0_d = rd_data;
        end else begin
          buf0_d = buf1_q;
          buf1_d = rd_data;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge r_clk) begin
    if (!r_rstn) begin
      inflight_q <= 1'b0;
      level_q    <= '0;
      buf0_q     <= '0;
      buf1_q     <= '0;
    end else begin
      inflight_q <= inflight_d;
      level_q    <= level_d;
      buf0_q     <= buf0_d;
      buf1_q     <= buf1_d;
    end
  end

`ifdef FIFO_RD_STREAM_CNT_EN
  logic [31:0] beat_cnt_q, beat_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    beat_cnt_d  = beat_cnt_q + {31'd0, pop};
    stall_cnt_d = stall_cnt_q + {31'd0, m_valid & ~m_ready};
  end

  always_ff @(posedge r_clk) begin
    if (!r_rstn) begin
      beat_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      beat_cnt_q  <= beat_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign beat_cnt  = beat_cnt_q;
  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench for fifo_rd_stream with a small synchronous-read memory and
// registered empty-flag model standing in for the pointer controller.
module tb_fifo_rd_stream;

  logic       r_clk;
  logic       r_rstn;
  logic       r_empty;
  logic       r_en;
  logic [7:0] rd_data;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] m_data;
  logic [1:0] level;
`ifdef FIFO_RD_STREAM_CNT_EN
  logic [31:0] beat_cnt;
  logic [31:0] stall_cnt;
`endif

  fifo_rd_stream #(.DATA_WIDTH(8)) dut (
    .r_clk   (r_clk),
    .r_rstn  (r_rstn),
    .r_empty (r_empty),
    .r_en    (r_en),
    .rd_data (rd_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .level   (level)
`ifdef FIFO_RD_STREAM_CNT_EN
    ,
    .beat_cnt  (beat_cnt),
    .stall_cnt (stall_cnt)
`endif
  );

  initial r_clk = 1'b0;
  always #5 r_clk = ~r_clk;

  logic [7:0]  mem [0:255];
  int unsigned wptr;
  int unsigned rptr;

  // Memory / pointer model: reset flushes unread words, empty is registered.
  always @(posedge r_clk) begin
    if (!r_rstn) begin
      rptr    <= wptr;
      r_empty <= 1'b1;
      rd_data <= 8'hEE;
    end else begin
      rd_data <= r_en ? mem[rptr[7:0]] : 8'hEE;
      rptr    <= rptr + (r_en ? 1 : 0);
      r_empty <= (wptr == rptr + (r_en ? 1 : 0));
    end
  end

  int unsigned n_pass;
  int unsigned n_total;
  int unsigned exp_rd;
  int unsigned beats;
  int unsigned ren_pulses;
  int          cyc_n;
  int          first_beat;
  int          last_beat;
  logic [1:0]  max_lvl;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic wr(input logic [7:0] d);
    mem[wptr[7:0]] = d;
    wptr++;
  endtask

  task automatic cyc();
    if (r_empty === 1'b1) chk("ren_while_empty", 32'(r_en), 32'd0);
    if (level > max_lvl) max_lvl = level;
    if (r_en === 1'b1) ren_pulses++;
    if (m_valid === 1'b1 && m_ready === 1'b1) begin
      chk("beat_data", 32'(m_data), 32'(mem[exp_rd[7:0]]));
      exp_rd++;
      beats++;
      if (first_beat < 0) first_beat = cyc_n;
      last_beat = cyc_n;
    end
    @(posedge r_clk);
    #1;
    cyc_n++;
  endtask

  initial begin
    n_pass = 0; n_total = 0; exp_rd = 0; beats = 0; ren_pulses = 0;
    cyc_n = 0; first_beat = -1; last_beat = -1; max_lvl = '0;
    wptr = 0;
    r_rstn = 1'b0;
    m_ready = 1'b0;
    @(posedge r_clk); #1;
    @(posedge r_clk); #1;

    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_level",   32'(level),   32'd0);
    chk("rst_m_data",  32'(m_data),  32'd0);
    chk("rst_r_en",    32'(r_en),    32'd0);

    // Single word: latency empty-fall -> m_valid is 2 cycles
    r_rstn = 1'b1;
    exp_rd = wptr;
    wr(8'hA5);
    cyc();
    chk("sw_c0_r_en",    32'(r_en),    32'd1);
    chk("sw_c0_m_valid", 32'(m_valid), 32'd0);
    m_ready = 1'b1;
    cyc();
    chk("sw_c1_r_en",    32'(r_en),    32'd0);
    chk("sw_c1_m_valid", 32'(m_valid), 32'd0);
    cyc();
    chk("sw_c2_m_valid", 32'(m_valid), 32'd1);
    chk("sw_c2_m_data",  32'(m_data),  32'hA5);
    cyc();
    chk("sw_c3_m_valid", 32'(m_valid), 32'd0);
    chk("sw_c3_level",   32'(level),   32'd0);

    // Streaming 0x00..0x07 with m_ready held high
    beats = 0; first_beat = -1;
    for (int i = 0; i < 8; i++) wr(8'(i));
    for (int i = 0; i < 40 && beats < 8; i++) cyc();
    chk("st_beats", 32'(beats), 32'd8);
    chk("st_no_bubble", 32'(last_beat - first_beat), 32'd7);
    cyc(); cyc();
    chk("st_idle_level", 32'(level), 32'd0);

    // Backpressure: 10 stalled cycles then drain
    m_ready = 1'b0;
    beats = 0; ren_pulses = 0;
    for (int i = 0; i < 8; i++) wr(8'h10 + 8'(i));
    for (int i = 0; i < 10; i++) cyc();
    chk("bp_ren_pulses", 32'(ren_pulses), 32'd2);
    chk("bp_level",      32'(level),      32'd2);
    chk("bp_m_valid",    32'(m_valid),    32'd1);
    chk("bp_m_data",     32'(m_data),     32'h10);
    m_ready = 1'b1;
    #1;
    chk("bp_resume_ren", 32'(r_en), 32'd1);
    for (int i = 0; i < 40 && beats < 8; i++) cyc();
    chk("bp_beats", 32'(beats), 32'd8);

    // Toggling ready with 16 words
    beats = 0; max_lvl = '0;
    for (int i = 0; i < 16; i++) wr(8'h30 + 8'(i));
    for (int i = 0; i < 100 && beats < 16; i++) begin
      m_ready = (i % 2 == 0);
      cyc();
    end
    m_ready = 1'b1;
    chk("tg_beats", 32'(beats), 32'd16);
    chk("tg_level_bound", 32'(max_lvl <= 2'd2), 32'd1);
    cyc(); cyc(); cyc();
    chk("tg_drained_valid", 32'(m_valid), 32'd0);
    chk("tg_drained_beats", 32'(beats), 32'd16);

    // Reset mid-stream with level=1 and a read in flight
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) wr(8'h50 + 8'(i));
    cyc(); cyc(); cyc();
    chk("mr_pre_level", 32'(level), 32'd1);
    r_rstn = 1'b0;
    #1;
    chk("mr_ren_in_reset", 32'(r_en), 32'd0);
    cyc();
    chk("mr_m_valid", 32'(m_valid), 32'd0);
    chk("mr_level",   32'(level),   32'd0);
    chk("mr_m_data",  32'(m_data),  32'd0);
    cyc();
    r_rstn = 1'b1;
    exp_rd = wptr;
    beats = 0;
    m_ready = 1'b1;
    wr(8'h70);
    wr(8'h71);
    for (int i = 0; i < 20 && beats < 2; i++) cyc();
    chk("mr_new_beats", 32'(beats), 32'd2);
    cyc(); cyc(); cyc();
    chk("mr_no_stale", 32'(m_valid), 32'd0);
    chk("mr_total_beats", 32'(beats), 32'd2);

`ifdef FIFO_RD_STREAM_CNT_EN
    r_rstn = 1'b0;
    cyc(); cyc();
    chk("cnt_rst_beat",  beat_cnt,  32'd0);
    chk("cnt_rst_stall", stall_cnt, 32'd0);
    r_rstn = 1'b1;
    exp_rd = wptr;
    beats = 0;
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) wr(8'h90 + 8'(i));
    for (int i = 0; i < 10 && m_valid !== 1'b1; i++) cyc();
    chk("cnt_valid_seen", 32'(m_valid), 32'd1);
    cyc(); cyc(); cyc();
    m_ready = 1'b1;
    for (int i = 0; i < 20 && beats < 5; i++) cyc();
    cyc(); cyc();
    chk("cnt_beats_seen", 32'(beats), 32'd5);
    chk("cnt_beat",       beat_cnt,   32'd5);
    chk("cnt_stall",      stall_cnt,  32'd3);
    r_rstn = 1'b0;
    cyc();
    chk("cnt_rst2_beat",  beat_cnt,  32'd0);
    chk("cnt_rst2_stall", stall_cnt, 32'd0);
    r_rstn = 1'b1;
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
